// File: rtl/bgpu_dispatch_pkg.sv
// Shared types and constants for the thread-block dispatcher and its register file.
// Consumers: bgpu_tblock_dispatcher (state enum) and the dispatch register file (offsets, status pack).
package bgpu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } dispatch_state_e;

  localparam logic [31:0] DispatchRegBase = 32'hFFFF_FF00;
  localparam logic [7:0]  RegOffsetPc     = 8'h00;
  localparam logic [7:0]  RegOffsetDp     = 8'h04;
  localparam logic [7:0]  RegOffsetNum    = 8'h08;
  localparam logic [7:0]  RegOffsetTgid   = 8'h0C;
  localparam logic [7:0]  RegOffsetCtrl   = 8'h10;

  // Status word layout: bit0 start_pending, bit1 running, bit2 finished,
  // [11:4] finished_cnt, [31:24] dispatched_cnt; all other bits read as zero.
  function automatic logic [31:0] pack_status(
    input logic       start_pending,
    input logic       running,
    input logic       finished,
    input logic [7:0] finished_cnt,
    input logic [7:0] dispatched_cnt
  );
    logic [31:0] word;
    word        = '0;
    word[0]     = start_pending;
    word[1]     = running;
    word[2]     = finished;
    word[11:4]  = finished_cnt;
    word[31:24] = dispatched_cnt;
    return word;
  endfunction

endpackage

// File: rtl/bgpu_tblock_dispatcher_if.sv
// Launch, dispatch and completion signal bundle between register file, dispatcher and clusters.
// master = dispatcher side, slave = register-file/cluster side.
interface bgpu_tblock_dispatcher_if #(
  parameter int unsigned PcWidth       = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TblockIdxBits = 8,
  parameter int unsigned TgroupIdWidth = 8
);
  logic                     start;
  logic [PcWidth-1:0]       pc;
  logic [AddrWidth-1:0]     dp_addr;
  logic [TblockIdxBits-1:0] number_of_tblocks;
  logic [TgroupIdWidth-1:0] tgroup_id;

  logic                     disp_valid;
  logic                     disp_ready;
  logic [PcWidth-1:0]       disp_pc;
  logic [AddrWidth-1:0]     disp_dp_addr;
  logic [TgroupIdWidth-1:0] disp_tgroup_id;
  logic [TblockIdxBits-1:0] disp_tblock_idx;

  logic                     done_valid;
  logic                     done_ready;

  modport master (
    input  start, pc, dp_addr, number_of_tblocks, tgroup_id,
    input  disp_ready, done_valid,
    output disp_valid, disp_pc, disp_dp_addr, disp_tgroup_id, disp_tblock_idx,
    output done_ready
  );

  modport slave (
    output start, pc, dp_addr, number_of_tblocks, tgroup_id,
    output disp_ready, done_valid,
    input  disp_valid, disp_pc, disp_dp_addr, disp_tgroup_id, disp_tblock_idx,
    input  done_ready
  );
endinterface

// File: rtl/bgpu_tblock_dispatcher.sv
// Thread-block dispatcher: latches a kernel launch, hands out one request per block, counts completions.
// Optional BGPU_DISPATCH_PERF_EN adds a saturating launch_cycles_o counter.
module bgpu_tblock_dispatcher
  import bgpu_dispatch_pkg::*;
#(
  parameter int unsigned PcWidth       = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TblockIdxBits = 8,
  parameter int unsigned TgroupIdWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [PcWidth-1:0]       pc_i,
  input  logic [AddrWidth-1:0]     dp_addr_i,
  input  logic [TblockIdxBits-1:0] number_of_tblocks_i,
  input  logic [TgroupIdWidth-1:0] tgroup_id_i,
  output logic                     disp_valid_o,
  input  logic                     disp_ready_i,
  output logic [PcWidth-1:0]       disp_pc_o,
  output logic [AddrWidth-1:0]     disp_dp_addr_o,
  output logic [TgroupIdWidth-1:0] disp_tgroup_id_o,
  output logic [TblockIdxBits-1:0] disp_tblock_idx_o,
  input  logic                     done_valid_i,
  output logic                     done_ready_o,
  output logic                     start_pending_o,
  output logic                     running_o,
  output logic                     finished_o,
  output logic [TblockIdxBits-1:0] dispatched_cnt_o,
  output logic [TblockIdxBits-1:0] finished_cnt_o
`ifdef BGPU_DISPATCH_PERF_EN
  ,
  output logic [31:0]              launch_cycles_o
`endif
);

  dispatch_state_e          state_q, state_d;
  logic [PcWidth-1:0]       pc_q, pc_d;
  logic [AddrWidth-1:0]     dp_addr_q, dp_addr_d;
  logic [TblockIdxBits-1:0] num_q, num_d;
  logic [TgroupIdWidth-1:0] tgid_q, tgid_d;
  logic [TblockIdxBits-1:0] disp_cnt_q, disp_cnt_d;
  logic [TblockIdxBits-1:0] fin_cnt_q, fin_cnt_d;
  logic                     finished_q, finished_d;

  logic running;
  logic accept_start;
  logic disp_hs;
  logic done_acc;

  assign running      = (state_q == DISPATCH) || (state_q == DRAIN);
  assign accept_start = start_i && ((state_q == IDLE) || (state_q == DONE));

  // Valid depends only on registered state, so it never waits on ready.
  assign disp_valid_o = (state_q == DISPATCH) && (disp_cnt_q != num_q);
  assign disp_hs      = disp_valid_o && disp_ready_i;
  // The counter guard keeps an N=0 launch from counting a stray completion.
  assign done_acc     = done_valid_i && done_ready_o && (fin_cnt_q != num_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dp_addr_d  = dp_addr_q;
    num_d      = num_q;
    tgid_d     = tgid_q;
    disp_cnt_d = disp_cnt_q;
    fin_cnt_d  = fin_cnt_q;
    finished_d = finished_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          pc_d       = pc_i;
          dp_addr_d  = dp_addr_i;
          num_d      = number_of_tblocks_i;
          tgid_d     = tgroup_id_i;
          disp_cnt_d = '0;
          fin_cnt_d  = '0;
          finished_d = 1'b0;
          state_d    = DISPATCH;
        end
      end
      DISPATCH, DRAIN: begin
        if (disp_hs)  disp_cnt_d = disp_cnt_q + TblockIdxBits'(1);
        if (done_acc) fin_cnt_d  = fin_cnt_q + TblockIdxBits'(1);
        if (fin_cnt_d == num_q) begin
          state_d    = DONE;
          finished_d = 1'b1;
        end else if ((state_q == DISPATCH) && (disp_cnt_d == num_q)) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      dp_addr_q  <= '0;
      num_q      <= '0;
      tgid_q     <= '0;
      disp_cnt_q <= '0;
      fin_cnt_q  <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dp_addr_q  <= dp_addr_d;
      num_q      <= num_d;
      tgid_q     <= tgid_d;
      disp_cnt_q <= disp_cnt_d;
      fin_cnt_q  <= fin_cnt_d;
      finished_q <= finished_d;
    end
  end

  assign disp_pc_o         = pc_q;
  assign disp_dp_addr_o    = dp_addr_q;
  assign disp_tgroup_id_o  = tgid_q;
  assign disp_tblock_idx_o = disp_cnt_q;
  assign done_ready_o      = running;
  assign running_o         = running;
  assign finished_o        = finished_q;
  assign dispatched_cnt_o  = disp_cnt_q;
  assign finished_cnt_o    = fin_cnt_q;
  assign start_pending_o   = (state_q == DISPATCH) && (disp_cnt_q == '0) && (num_q != '0);

`ifdef BGPU_DISPATCH_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (accept_start) begin
      cycles_d = '0;
    end else if (running && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign launch_cycles_o = cycles_q;
`else
  logic unused_accept_start;
  assign unused_accept_start = accept_start;
`endif

endmodule

// File: tb/tb_bgpu_tblock_dispatcher.sv
// Randomized and directed bench for bgpu_tblock_dispatcher against a launch-level reference model.
// Build with BGPU_DISPATCH_PERF_EN to also cover launch_cycles_o.
module tb_bgpu_tblock_dispatcher;
  import bgpu_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bgpu_tblock_dispatcher_if #(
    .PcWidth(32), .AddrWidth(32), .TblockIdxBits(8), .TgroupIdWidth(8)
  ) dif ();

  logic       start_pending, running, finished;
  logic [7:0] disp_cnt, fin_cnt;
`ifdef BGPU_DISPATCH_PERF_EN
  logic [31:0] launch_cycles;
`endif

  bgpu_tblock_dispatcher #(
    .PcWidth(32), .AddrWidth(32), .TblockIdxBits(8), .TgroupIdWidth(8)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (dif.start),
    .pc_i               (dif.pc),
    .dp_addr_i          (dif.dp_addr),
    .number_of_tblocks_i(dif.number_of_tblocks),
    .tgroup_id_i        (dif.tgroup_id),
    .disp_valid_o       (dif.disp_valid),
    .disp_ready_i       (dif.disp_ready),
    .disp_pc_o          (dif.disp_pc),
    .disp_dp_addr_o     (dif.disp_dp_addr),
    .disp_tgroup_id_o   (dif.disp_tgroup_id),
    .disp_tblock_idx_o  (dif.disp_tblock_idx),
    .done_valid_i       (dif.done_valid),
    .done_ready_o       (dif.done_ready),
    .start_pending_o    (start_pending),
    .running_o          (running),
    .finished_o         (finished),
    .dispatched_cnt_o   (disp_cnt),
    .finished_cnt_o     (fin_cnt)
`ifdef BGPU_DISPATCH_PERF_EN
    ,
    .launch_cycles_o    (launch_cycles)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch-level reference: a launch is waiting, handing out blocks, waiting on completions, or complete.
  typedef enum {M_IDLE, M_SENDING, M_WAITING, M_COMPLETE} mphase_e;
  mphase_e m_phase;
  logic [31:0] m_pc, m_dp;
  logic [7:0]  m_tg;
  int          m_n, m_sent, m_done;
  bit          m_fin;
  longint      m_cyc;

  function automatic void model_reset();
    m_phase = M_IDLE; m_pc = '0; m_dp = '0; m_tg = '0;
    m_n = 0; m_sent = 0; m_done = 0; m_fin = 0; m_cyc = 0;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_phase == M_IDLE || m_phase == M_COMPLETE) begin
      if (dif.start) begin
        m_pc = dif.pc; m_dp = dif.dp_addr; m_tg = dif.tgroup_id;
        m_n = int'(dif.number_of_tblocks);
        m_sent = 0; m_done = 0; m_fin = 0; m_cyc = 0;
        m_phase = M_SENDING;
      end
    end else begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (m_phase == M_SENDING && m_sent < m_n && dif.disp_ready) m_sent++;
      if (dif.done_valid && m_done < m_n) m_done++;
      if (m_done == m_n) begin
        m_phase = M_COMPLETE; m_fin = 1;
      end else if (m_phase == M_SENDING && m_sent == m_n) begin
        m_phase = M_WAITING;
      end
    end
  endfunction

  task automatic check_all();
    bit act;
    act = (m_phase == M_SENDING) || (m_phase == M_WAITING);
    chk("disp_valid", dif.disp_valid, (m_phase == M_SENDING) && (m_sent < m_n));
    chk("disp_idx",   dif.disp_tblock_idx, m_sent);
    chk("disp_pc",    dif.disp_pc, m_pc);
    chk("disp_dp",    dif.disp_dp_addr, m_dp);
    chk("disp_tgid",  dif.disp_tgroup_id, m_tg);
    chk("done_ready", dif.done_ready, act);
    chk("running",    running, act);
    chk("start_pend", start_pending, (m_phase == M_SENDING) && m_sent == 0 && m_n != 0);
    chk("finished",   finished, m_fin);
    chk("disp_cnt",   disp_cnt, m_sent);
    chk("fin_cnt",    fin_cnt, m_done);
`ifdef BGPU_DISPATCH_PERF_EN
    chk("launch_cyc", launch_cycles, m_cyc);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic launch(input int n, input logic [31:0] pc, input logic [31:0] dp, input logic [7:0] tg);
    dif.start = 1'b1; dif.pc = pc; dif.dp_addr = dp;
    dif.number_of_tblocks = 8'(n); dif.tgroup_id = tg;
    tick();
    dif.start = 1'b0; dif.pc = $urandom; dif.dp_addr = $urandom;
    dif.number_of_tblocks = 8'($urandom); dif.tgroup_id = 8'($urandom);
  endtask

  task automatic finish_launch(input string tag);
    int guard;
    guard = 0;
    dif.disp_ready = 1'b1;
    while (m_phase != M_COMPLETE && m_phase != M_IDLE && guard < 1000) begin
      dif.done_valid = (m_done < m_sent);
      tick();
      guard++;
    end
    dif.done_valid = 1'b0;
    if (guard >= 1000) chk({tag, "_timeout"}, 0, 1);
  endtask

  logic [7:0] idx_seen[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dif.start = 1'b0; dif.pc = '0; dif.dp_addr = '0; dif.number_of_tblocks = '0; dif.tgroup_id = '0;
    dif.disp_ready = 1'b0; dif.done_valid = 1'b0;
    model_reset();
    tick(); tick();
    chk("reset_all_zero", {dif.disp_valid, dif.done_ready, running, finished, start_pending,
                           disp_cnt, fin_cnt, dif.disp_pc}, '0);
    rst_n = 1'b1;
    tick();

    // N=1 single block, status word after completion
    dif.disp_ready = 1'b1;
    launch(1, 32'h0, 32'h1C0, 8'd2);
    chk("t1_valid", dif.disp_valid, 1);
    chk("t1_idx", dif.disp_tblock_idx, 0);
    chk("t1_dp", dif.disp_dp_addr, 32'h1C0);
    tick();
    dif.done_valid = 1'b1;
    tick();
    dif.done_valid = 1'b0;
    chk("t1_finished", finished, 1);
    chk("t1_status", pack_status(start_pending, running, finished, fin_cnt, disp_cnt), 32'h0100_0014);

    // N=4 with ready toggling every cycle
    launch(4, 32'hCAFE_0000, 32'h2000, 8'd7);
    idx_seen.delete();
    for (int unsigned c = 0; c < 40 && m_phase == M_SENDING; c++) begin
      dif.disp_ready = c[0];
      if (dif.disp_valid && dif.disp_ready) idx_seen.push_back(dif.disp_tblock_idx);
      tick();
    end
    chk("t2_count", idx_seen.size(), 4);
    foreach (idx_seen[i]) chk("t2_idx_seq", idx_seen[i], i);
    chk("t2_disp_cnt", disp_cnt, 4);
    finish_launch("t2");

    // N=3, completion in the same cycle as handshake for idx 1
    dif.disp_ready = 1'b1;
    launch(3, 32'h100, 32'h300, 8'd3);
    tick();
    dif.done_valid = 1'b1;
    tick();
    chk("t3_both_disp", disp_cnt, 2);
    chk("t3_both_fin", fin_cnt, 1);
    tick();
    chk("t3_not_done", finished, 0);
    tick();
    dif.done_valid = 1'b0;
    chk("t3_done", finished, 1);
    chk("t3_fin_cnt", fin_cnt, 3);

    // N=0 completes with no dispatch
    launch(0, 32'h40, 32'h80, 8'd1);
    chk("t4_no_valid0", dif.disp_valid, 0);
    chk("t4_not_yet", finished, 0);
    tick();
    chk("t4_no_valid1", dif.disp_valid, 0);
    chk("t4_finished", finished, 1);

    // start during DRAIN is ignored
    launch(2, 32'h1234, 32'h10, 8'd4);
    tick(); tick();
    dif.start = 1'b1; dif.pc = 32'hDEAD_BEEF; dif.number_of_tblocks = 8'd9;
    tick();
    dif.start = 1'b0;
    chk("t5_pc_kept", dif.disp_pc, 32'h1234);
    chk("t5_running", running, 1);
    chk("t5_no_valid", dif.disp_valid, 0);
    finish_launch("t5");

    // reset mid-DISPATCH
    dif.disp_ready = 1'b0;
    launch(5, 32'h5555, 32'h66, 8'd8);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_reset_zero", {dif.disp_valid, dif.done_ready, running, finished, start_pending,
                          disp_cnt, fin_cnt, dif.disp_pc, dif.disp_dp_addr}, '0);
    rst_n = 1'b1;
    dif.done_valid = 1'b1;
    tick();
    dif.done_valid = 1'b0;
    chk("t6_late_done", fin_cnt, 0);

`ifdef BGPU_DISPATCH_PERF_EN
    // N=2, one stall, 5-cycle drain: 3 + 5 cycles in flight
    dif.disp_ready = 1'b0;
    launch(2, 32'h77, 32'h88, 8'd9);
    tick();
    dif.disp_ready = 1'b1;
    tick(); tick();
    for (int unsigned c = 0; c < 5; c++) begin
      dif.done_valid = (c >= 3);
      tick();
    end
    dif.done_valid = 1'b0;
    chk("perf_done", finished, 1);
    chk("perf_cycles", launch_cycles, 8);
    tick();
    chk("perf_hold", launch_cycles, 8);
`endif

    // randomized launches, including the maximum block count
    for (int unsigned l = 0; l < 30; l++) begin
      int n, guard;
      n = (l == 7) ? 255 : int'($urandom_range(0, 12));
      launch(n, $urandom, $urandom, 8'($urandom));
      guard = 0;
      while (m_phase != M_COMPLETE && m_phase != M_IDLE && guard < 3000) begin
        dif.disp_ready = ($urandom % 3) != 0;
        dif.done_valid = (m_done < m_sent) && (($urandom % 2) == 0);
        dif.start = ($urandom % 16) == 0;
        rst_n = ($urandom % 400) != 0;
        tick();
        guard++;
      end
      dif.start = 1'b0; dif.done_valid = 1'b0; rst_n = 1'b1;
      if (guard >= 3000) chk("rand_timeout", 0, 1);
      dif.done_valid = ($urandom % 2) == 0;
      tick();
      dif.done_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bgpu_tblock_dispatcher.md
# bgpu_tblock_dispatcher

Thread-block dispatcher behind the memory-mapped dispatch register file at 0xFFFFFF00–0xFFFFFF10. On a start command it latches the kernel launch parameters: PC, data-pointer address, thread-block count and thread-group ID. It then issues one dispatch request per thread block to the compute clusters over a valid/ready handshake. It counts completions and exposes the running, finished and counter status that the register file packs into the status word at 0xFFFFFF10.

## Interface

Parameters:
- PcWidth, 32, width of the kernel start PC
- AddrWidth, 32, width of the data-pointer address
- TblockIdxBits, 8, width of the block count, the block index and both counters
- TgroupIdWidth, 8, width of the thread-group ID

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  single-cycle launch pulse from the register file
- pc_i  in  PcWidth  kernel start PC
- dp_addr_i  in  AddrWidth  data-pointer address
- number_of_tblocks_i  in  TblockIdxBits  number of blocks to launch (N)
- tgroup_id_i  in  TgroupIdWidth  thread-group ID
- disp_valid_o  out  1  dispatch request valid
- disp_ready_i  in  1  cluster accepts the request
- disp_pc_o  out  PcWidth  latched PC
- disp_dp_addr_o  out  AddrWidth  latched data pointer
- disp_tgroup_id_o  out  TgroupIdWidth  latched group ID
- disp_tblock_idx_o  out  TblockIdxBits  index of the current block
- done_valid_i  in  1  a cluster reports one block finished
- done_ready_o  out  1  completion accepted
- start_pending_o  out  1  a start is latched but the first dispatch has not been issued
- running_o  out  1  a launch is in progress
- finished_o  out  1  the last launch is complete
- dispatched_cnt_o  out  TblockIdxBits  blocks handed out
- finished_cnt_o  out  TblockIdxBits  blocks completed

## Operation

States are IDLE, DISPATCH, DRAIN and DONE.

- IDLE/DONE + start_i:
  - latch pc, dp_addr, N and tgroup_id;
  - clear both counters and finished_o;
  - go to DISPATCH.
- start_i in DISPATCH or DRAIN is ignored. No queuing, no effect on the latched parameters.
- DISPATCH:
  - disp_valid_o = 1 and disp_tblock_idx_o = dispatched_cnt_o;
  - a handshake (valid && ready) increments dispatched_cnt_o;
  - when the handshake for index N-1 occurs, go to DRAIN.
- DRAIN: no requests are issued; wait for the completion count to reach N.
- Completions:
  - done_ready_o = 1 in DISPATCH and DRAIN, 0 in IDLE and DONE;
  - each done_valid_i && done_ready_o increments finished_cnt_o;
  - completions presented while done_ready_o = 0 are not counted and not accepted.
- A dispatch handshake and a completion in the same cycle both update their counters.
- When finished_cnt_o reaches N (counting any completion in the current cycle), go to DONE; finished_o is set. It holds until the next start_i or reset.
- N = 0: the transition goes IDLE → DISPATCH → DONE with disp_valid_o held low throughout and no dispatch issued.
- Derived status:
  - running_o = (state is DISPATCH or DRAIN);
  - start_pending_o = DISPATCH && dispatched_cnt_o == 0 && N != 0.
- Counters are TblockIdxBits wide and never wrap. N is at most 2^TblockIdxBits − 1.

## Timing

- Reset values:
  - state IDLE;
  - all outputs 0;
  - latched payload 0.
- Reset asserted mid-launch aborts the launch to IDLE on the next edge. Outstanding completions arriving after reset are ignored.
- Latencies:
  - start_i to disp_valid_o high: 1 cycle;
  - back-to-back dispatch at 1 block per cycle while disp_ready_i = 1;
  - final completion to finished_o high: 1 cycle.
- Once disp_valid_o is raised, it and all disp_* payload stay stable until the handshake. disp_valid_o does not depend combinationally on disp_ready_i.
- done_ready_o is a registered function of state only.

## Configuration

- BGPU_DISPATCH_PERF_EN defined:
  - adds output launch_cycles_o (32 bits);
  - the counter clears on an accepted start and increments every cycle in DISPATCH or DRAIN;
  - it saturates at 2^32−1 and holds in DONE;
  - reset value 0.
- Macro undefined: the port and the counter do not exist, and the remaining behaviour is identical.

## Structure

- Shared package bgpu_dispatch_pkg contains:
  - the state enum `dispatch_state_e`;
  - the register offsets (PC 0x00, DP 0x04, NUM 0x08, TGID 0x0C, CTRL/STATUS 0x10);
  - a status-pack function producing the 32-bit status word: bit0 start_pending, bit1 running, bit2 finished, [11:4] finished_cnt, [31:24] dispatched_cnt.
- No sub-module. The state machine and counters are inline.

## Test plan

- N=1, pc=0x0, dp_addr=0x1C0, tgid=2, ready always 1:
  - one request with idx 0 and the latched payload;
  - after one done_valid_i pulse, finished_o=1 and status word = 0x0100_0014.
- N=4, disp_ready_i toggling every other cycle: idx sequence 0,1,2,3 with the payload held stable across every stall cycle; dispatched_cnt_o=4.
- N=3 with a completion in the same cycle as the handshake for idx 1: both counters update that cycle; DONE is reached after the 3rd completion.
- N=0: no disp_valid_o ever; finished_o=1 two cycles after start_i.
- Run these two checks as separate launches so each starts from the same state:
  - start_i during DRAIN of an N=2 launch is ignored and the latched pc is unchanged;
  - rst_ni low mid-DISPATCH gives state IDLE and all outputs 0 on the next edge.
- With BGPU_DISPATCH_PERF_EN defined, N=2, one stall cycle and a 5-cycle drain: launch_cycles_o equals the number of cycles spent in DISPATCH plus DRAIN.
